// File: rtl/noc_out_arbiter.sv
// Wormhole output-port arbiter: round-robin pick among header-eligible inputs, then lock for a whole packet.
// Latency: lock one cycle after eligibility; grants are combinational from lock state, req and out_ready.
// Backpressure: out_ready=0 or a missing owner req stalls the grant; the lock and flit count hold indefinitely.
module noc_out_arbiter #(
    parameter int NUM_IN    = 5,
    parameter int LEN_WIDTH = 12,
    parameter int IDX_W     = $clog2(NUM_IN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           req,
    input  logic [NUM_IN-1:0]           head,
    input  logic [NUM_IN*LEN_WIDTH-1:0] len,
    input  logic                        out_ready,
    output logic [NUM_IN-1:0]           grant,
    output logic [IDX_W-1:0]            owner,
    output logic                        busy,
    output logic [LEN_WIDTH-1:0]        flits_left,
    output logic                        pkt_done
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0] flits_q, flits_d;
    logic                 done_q, done_d;

    logic [NUM_IN-1:0]    elig;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [LEN_WIDTH-1:0] win_len;
    logic                 gnt_any;

    assign elig = req & head;

    // Two passes: inputs above the last winner first, then wrap to the rest.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_len = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!win_vld && elig[i] && (IDX_W'(i) > ptr_q)) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
                win_len = len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!win_vld && elig[i] && (IDX_W'(i) <= ptr_q)) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
                win_len = len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            grant[i] = (state_q == S_LOCKED) && out_ready && req[i] && (owner_q == IDX_W'(i));
        end
    end

    assign gnt_any = |grant;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        flits_d = flits_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_LOCKED;
                    owner_d = win_idx;
                    // A zero length still carries the header flit.
                    flits_d = (win_len == '0) ? LEN_WIDTH'(1) : win_len;
                end
            end
            S_LOCKED: begin
                if (gnt_any) begin
                    if (flits_q == LEN_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        ptr_d   = owner_q;
                        flits_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        flits_d = flits_q - LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_IN - 1);
            flits_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            flits_q <= flits_d;
            done_q  <= done_d;
        end
    end

    assign owner      = owner_q;
    assign busy       = (state_q == S_LOCKED);
    assign flits_left = flits_q;
    assign pkt_done   = done_q;

endmodule
